data_mem: RTL and testbench
===========================

# data_mem

Synchronous data-memory responder on the load/store side of the MEM stage. It accepts one word-wide request from the MEM stage (`ce_i`/`we_i`/`addr_i`/`sel_i`/`data_i`) and performs a byte-enabled write or a full-word read on an internal word array after a programmable number of wait states. It returns the read word with a one-cycle `ack_o` pulse and raises `stallreq_o` toward pipeline control while the access is outstanding. Byte-lane extraction and sign extension for LB/LH/LW stay in the MEM stage.

## Interface
- `ADDR_WIDTH`, default 10: word-address width. Depth is 2^ADDR_WIDTH words.
- `WAIT_STATES`, default 1: extra BUSY cycles before the access. Legal range 0–15.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `ce_i`: input, 1 bit. Request valid from MEM.
- `we_i`: input, 1 bit. 1 = store, 0 = load.
- `addr_i`: input, 32 bits. Byte address. Bits [1:0] are ignored.
- `sel_i`: input, 4 bits. Byte enables, big-endian: sel[3] enables data[31:24] (byte offset 0); sel[0] enables data[7:0] (offset 3).
- `data_i`: input, 32 bits. Store data, already lane-aligned.
- `data_o`: output, 32 bits. Read word. Valid only while `ack_o`=1.
- `ack_o`: output, 1 bit. Registered. One-cycle completion pulse.
- `stallreq_o`: output, 1 bit. Combinational. Stall request to pipeline control.

## Operation
- **States:** IDLE, BUSY, DONE. 4-bit wait counter `cnt`.
- **IDLE:**
  - `ce_i`=1 at the edge: latch `we_i`, word index, `sel_i`, `data_i`; load `cnt`=WAIT_STATES; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY:**
  - `cnt`≠0: decrement `cnt`, stay in BUSY.
  - `cnt`=0, write: for each set sel bit, write the latched byte into the word. Bytes with a clear sel bit are unchanged.
  - `cnt`=0, read: capture the full word into the read-data register regardless of sel.
  - After the access, go to DONE.
- **DONE:**
  - `ack_o`=1.
  - `data_o` = captured word on reads, 0 on writes.
  - Unconditional return to IDLE. A request is never re-sampled in DONE, so one instruction yields exactly one access.
- **Word index:** `addr_i[ADDR_WIDTH+1:2]`. Higher address bits are ignored, so addresses alias modulo 4·2^ADDR_WIDTH bytes.
- **Stall:** `stallreq_o` = `ce_i` AND (state ≠ DONE). Consequences:
  - The pipeline holds MEM inputs stable through IDLE and BUSY.
  - It advances at the end of DONE.
  - In the cycle after DONE, `ce_i` belongs to the next instruction.
- **Write with `sel_i`=0000:** no byte changes; full handshake still occurs.
- **`ce_i` dropped mid-transaction** (flush after latching): the latched access still completes (a write still commits) and `ack_o` still pulses. `stallreq_o` follows `ce_i`, so it is 0.
- **Input changes after latching** are ignored until the next IDLE.

## Timing
- **Reset:**
  - state=IDLE, `cnt`=0, `ack_o`=0, `data_o`=0x00000000, read register=0.
  - `stallreq_o` = `ce_i` (state is IDLE).
  - Memory contents are not cleared.
- **Reset mid-operation:**
  - `rst` wins over every transition.
  - A write whose access edge coincides with or follows `rst` assertion is discarded.
  - A pending `ack_o` never appears.
- **Latency:** request first seen in cycle 0 (IDLE) → `ack_o` in cycle 2+WAIT_STATES. Occupancy is 3+WAIT_STATES cycles per access.
- **`stallreq_o`:** high in cycles 0 … 1+WAIT_STATES; low in the ack cycle.
- **Back-to-back requests:** the next request is sampled in the IDLE cycle after DONE. No pipelining, one outstanding access.
- **Read-after-write to the same word:** the read returns the new data, since the write completes before the next request is latched.

## Test plan
- **Full-word store, WAIT_STATES=1:** reset, then store 0x12345678 to 0x00000010 with sel=1111 at cycle 0 → `stallreq_o`=1 in cycles 0–2, `ack_o`=1 only in cycle 3, `data_o`=0 in cycle 3.
- **Byte store then load:** after the above, store 0x00AB0000 to 0x10 with sel=0100, then load 0x10 → `data_o`=0x12AB5678 with `ack_o`. Then store sel=0000 and load again → still 0x12AB5678.
- **WAIT_STATES=0 load:** load of 0x10 issued in cycle 0 → `ack_o` in cycle 2, `stallreq_o` high in cycles 0–1 only, DONE→IDLE in cycle 3.
- **Aliasing:** with ADDR_WIDTH=10, load 0x00001010 → returns the word at 0x10 (0x12AB5678). Store 0xDEADBEEF to 0x00001010, then load 0x10 → 0xDEADBEEF.
- **Reset in BUSY:** store 0xCAFEF00D to 0x20 (WAIT_STATES=3), assert `rst` in cycle 2 for 1 cycle → no `ack_o`, `data_o`=0. A subsequent load of 0x20 returns the pre-store value.
- **Flush mid-transaction:** store 0x55AA55AA to 0x30, drop `ce_i` in cycle 1 → `stallreq_o`=0 from cycle 1, `ack_o` still pulses in cycle 2+WAIT_STATES, and a later load of 0x30 returns 0x55AA55AA.

Source files
------------

// File: rtl/data_mem.sv
// Word-wide data-memory responder for the MEM stage: byte-enabled stores and
// full-word loads after a fixed number of wait states, with ack and stall handshake.
module data_mem #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        stallreq_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  ack_q;
    logic                  access;
    logic                  unused_addr_bits;

    logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    // Upper address bits alias; the low two select a byte lane handled upstream.
    assign unused_addr_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    assign access = (state_q == S_BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ce_i) begin
                    state_d = S_BUSY;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= access;
            if (state_q == S_IDLE && ce_i) begin
                we_q    <= we_i;
                idx_q   <= addr_i[ADDR_WIDTH+1:2];
                sel_q   <= sel_i;
                wdata_q <= data_i;
            end
            // Stores leave zero in the read register so data_o reads 0 on their ack.
            if (access) rdata_q <= we_q ? '0 : mem_q[idx_q];
        end
    end

    // Array is never reset; a store is dropped if reset coincides with its access edge.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (sel_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign ack_o      = ack_q;
    assign data_o     = ack_q ? rdata_q : '0;
    assign stallreq_o = ce_i && (state_q != S_DONE);

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: three instances with WAIT_STATES 1, 0 and 3,
// directed stimulus pushes expected acks, a monitor pops them as acks appear.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        ce    [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  sel   [3];
    logic [31:0] din   [3];
    logic [31:0] dout  [3];
    logic        ack   [3];
    logic        stall [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          k;
        logic [31:0] d;
        int          at;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem #(
            .ADDR_WIDTH (10),
            .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .ce_i      (ce[g]),
            .we_i      (we[g]),
            .addr_i    (addr[g]),
            .sel_i     (sel[g]),
            .data_i    (din[g]),
            .data_o    (dout[g]),
            .ack_o     (ack[g]),
            .stallreq_o(stall[g])
        );
    end

    function automatic int ws(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ack and flags missing or unexpected acks.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ack[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ack_dut", 32'(k), 32'(e.k));
                    chk("ack_data", dout[k], e.d);
                    chk("ack_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
        if (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            chk("missing_ack", 32'(cyc), 32'(e.at));
        end
    end

    // One access; drop_at / rst_at (>=0) flush ce or pulse reset at that cycle index.
    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input logic [31:0] expd, input int drop_at, input int rst_at);
        int  last;
        logic exp_st;
        last = (rst_at >= 0) ? 2 + ws(k) + 2 : 2 + ws(k);
        @(negedge clk);
        ce[k]   = 1'b1;
        we[k]   = w;
        addr[k] = a;
        sel[k]  = s;
        din[k]  = d;
        if (rst_at < 0) sb.push_back('{k, expd, cyc + 2 + ws(k)});
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) ce[k] = 1'b0;
            if (rst_at >= 0 && c == rst_at) begin
                rst[k] = 1'b1;
                ce[k]  = 1'b0;
            end
            if (rst_at >= 0 && c == rst_at + 1) rst[k] = 1'b0;
            #1;
            exp_st = (c < 2 + ws(k)) && (drop_at < 0 || c < drop_at) && (rst_at < 0 || c < rst_at);
            chk("stallreq", 32'(stall[k]), 32'(exp_st));
            if (rst_at >= 0 && c >= rst_at) begin
                chk("rst_no_ack", 32'(ack[k]), 32'd0);
                chk("rst_data", dout[k], 32'd0);
            end
        end
        ce[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; ce[k] = 1'b0; we[k] = 1'b0;
            addr[k] = '0; sel[k] = '0; din[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'd0);
            chk("reset_data", dout[k], 32'd0);
            chk("reset_stall_ce0", 32'(stall[k]), 32'd0);
            ce[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 3; k++) chk("reset_stall_ce1", 32'(stall[k]), 32'd1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_hold_ack", 32'(ack[k]), 32'd0);
            ce[k]  = 1'b0;
            rst[k] = 1'b0;
        end

        // WAIT_STATES=1: stores, byte store, empty-sel store, aliasing, flush.
        access(0, 1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0, -1, -1);
        access(0, 1'b1, 32'h0000_0010, 4'b0100, 32'h00AB_0000, 32'h0, -1, -1);
        access(0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h12AB_5678, -1, -1);
        access(0, 1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0, -1, -1);
        access(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h12AB_5678, -1, -1);
        access(0, 1'b0, 32'h0000_1010, 4'b1111, 32'h0,         32'h12AB_5678, -1, -1);
        access(0, 1'b1, 32'h0000_1010, 4'b1111, 32'hDEAD_BEEF, 32'h0, -1, -1);
        access(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF, -1, -1);
        access(0, 1'b1, 32'h0000_0030, 4'b1111, 32'h55AA_55AA, 32'h0, 1, -1);
        access(0, 1'b0, 32'h0000_0033, 4'b0001, 32'h0,         32'h55AA_55AA, -1, -1);
        access(0, 1'b1, 32'h0000_0030, 4'b0011, 32'h0000_1234, 32'h0, -1, -1);
        access(0, 1'b0, 32'h0000_0030, 4'b1111, 32'h0,         32'h55AA_1234, -1, -1);

        // WAIT_STATES=0: minimum latency and back-to-back loads.
        access(1, 1'b1, 32'h0000_0010, 4'b1111, 32'h12AB_5678, 32'h0, -1, -1);
        access(1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h12AB_5678, -1, -1);
        access(1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'h12AB_5678, -1, -1);

        // WAIT_STATES=3: reset during BUSY discards the store.
        access(2, 1'b1, 32'h0000_0020, 4'b1111, 32'h1111_2222, 32'h0, -1, -1);
        access(2, 1'b1, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 32'h0, -1, 2);
        access(2, 1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h1111_2222, -1, -1);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
